reg_file_mp: RTL and testbench

- Parametrised multi-port integer register file; successor to the single-write, two-read register file in the CPU datapath.
- Adds configurable width, depth and read-port count, plus a second write port with fixed priority.
- Adds a hard-wired zero register, a post-reset clear sweep, and a per-register busy scoreboard for the decode/issue stage.
- Instantiated by the decode stage; write ports are driven by the writeback stage (port 0 = ALU, port 1 = load unit).

---
 rtl/reg_file_mp_if.sv | 30 +++
 rtl/reg_file_mp.sv | 127 ++++++++++++
 tb/tb_reg_file_mp.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/reg_file_mp_if.sv
// Bundle of write, read and scoreboard signals between the decode/writeback stages and reg_file_mp.
// The master side drives addresses and write data; the slave (register file) returns read data and busy bits.
interface reg_file_mp_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2
);
  logic                init_done;
  logic                wen0;
  logic [AW-1:0]       waddr0;
  logic [XLEN-1:0]     wdata0;
  logic                wen1;
  logic [AW-1:0]       waddr1;
  logic [XLEN-1:0]     wdata1;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic                sb_set;
  logic [AW-1:0]       sb_addr;

  modport master (
    input  init_done, rdata, rbusy,
    output wen0, waddr0, wdata0, wen1, waddr1, wdata1, raddr, sb_set, sb_addr
  );

  modport slave (
    output init_done, rdata, rbusy,
    input  wen0, waddr0, wdata0, wen1, waddr1, wdata1, raddr, sb_set, sb_addr
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file: two write ports (port 1 wins), NRD combinational reads, zero register,
// post-reset clear sweep and busy scoreboard. Define REG_FILE_MP_BYPASS_EN for same-cycle write-to-read forwarding.
module reg_file_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_mp_if.slave  bus
);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   cnt_reg, cnt_next;
  logic            run;

  logic [XLEN-1:0] mem [NREGS];
  logic [NREGS-1:0] busy_reg, busy_next;

  logic we0, we1, clr0, clr1, sb_eff;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_INIT: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == AW'(NREGS - 1))
          state_next = ST_RUN;
      end
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_INIT;
    endcase
  end

  // Output logic
  always_comb begin
    run           = (state_reg == ST_RUN);
    bus.init_done = run;
  end

  // Write qualification: port 0 drops out when port 1 targets the same entry.
  always_comb begin
    we1    = run && bus.wen1 && !(ZERO_REG != 0 && bus.waddr1 == '0);
    we0    = run && bus.wen0 && !(ZERO_REG != 0 && bus.waddr0 == '0)
                 && !(we1 && bus.waddr1 == bus.waddr0);
    clr0   = run && bus.wen0;
    clr1   = run && bus.wen1;
    sb_eff = run && bus.sb_set && !(ZERO_REG != 0 && bus.sb_addr == '0);
  end

  // Array is cleared by the sweep rather than by reset, so it keeps a plain clocked write.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[cnt_reg] <= '0;
    end else begin
      if (we0) mem[bus.waddr0] <= bus.wdata0;
      if (we1) mem[bus.waddr1] <= bus.wdata1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_busy
      logic set_hit, clr_hit;
      assign set_hit = sb_eff && (bus.sb_addr == AW'(gi));
      assign clr_hit = (clr0 && bus.waddr0 == AW'(gi)) || (clr1 && bus.waddr1 == AW'(gi));
      // A new producer issued in the same cycle as the old one retires keeps the entry busy.
      assign busy_next[gi] = set_hit ? 1'b1 : (clr_hit ? 1'b0 : busy_reg[gi]);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_reg <= '0;
    else     busy_reg <= busy_next;
  end

  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] rd;
      logic            rb;

      assign ra = bus.raddr[gi*AW +: AW];

      always_comb begin
        rd = mem[ra];
        rb = busy_reg[ra];
`ifdef REG_FILE_MP_BYPASS_EN
        if (we0 && bus.waddr0 == ra) rd = bus.wdata0;
        if (we1 && bus.waddr1 == ra) rd = bus.wdata1;
        if (((clr0 && bus.waddr0 == ra) || (clr1 && bus.waddr1 == ra))
            && !(sb_eff && bus.sb_addr == ra))
          rb = 1'b0;
`endif
        if (ZERO_REG != 0 && ra == '0) begin
          rd = '0;
          rb = 1'b0;
        end
        if (!run) begin
          rd = '0;
          rb = 1'b0;
        end
      end

      assign bus.rdata[gi*XLEN +: XLEN] = rd;
      assign bus.rbusy[gi]              = rb;
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp (default parameters): sweep, dual writes, zero register, scoreboard, forwarding.
module tb_reg_file_mp;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int NRD = 2;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  reg_file_mp_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD)) bus ();

  reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
    $display("[TB] %s observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts rising edges until init_done; bounded so a stuck sweep still reaches the summary.
  task automatic wait_init(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (bus.init_done !== 1'b1 && n < 100);
    check(tag, 32'(n), 32'(NREGS));
  endtask

  task automatic idle();
    bus.wen0 = 1'b0; bus.waddr0 = '0; bus.wdata0 = '0;
    bus.wen1 = 1'b0; bus.waddr1 = '0; bus.wdata1 = '0;
    bus.sb_set = 1'b0; bus.sb_addr = '0;
  endtask

  initial begin
    idle();
    bus.raddr = {5'd0, 5'd5};
    step();
    step();
    check("reset_init_done", {31'd0, bus.init_done}, 32'd0);
    check("reset_rdata", bus.rdata[31:0], 32'h0);
    check("reset_rbusy", {30'd0, bus.rbusy}, 32'd0);
    rst = 1'b0;
    wait_init("first_sweep_len");

    // Preload entry 5, then reset and confirm the sweep cleared it
    bus.wen0 = 1'b1; bus.waddr0 = 5'd5; bus.wdata0 = 32'hDEADBEEF;
    step();
    idle();
    #1;
    check("preload_read", bus.rdata[31:0], 32'hDEADBEEF);
    rst = 1'b1;
    #2;
    check("async_rst_init_done", {31'd0, bus.init_done}, 32'd0);
    check("async_rst_rdata", bus.rdata[31:0], 32'h0);
    step();
    rst = 1'b0;
    wait_init("sweep_len");
    #1;
    check("swept_entry5", bus.rdata[31:0], 32'h0);

    // Same-address dual write: port 1 wins
    bus.wen0 = 1'b1; bus.waddr0 = 5'd7; bus.wdata0 = 32'h11111111;
    bus.wen1 = 1'b1; bus.waddr1 = 5'd7; bus.wdata1 = 32'h22222222;
    step();
    idle();
    bus.raddr = {5'd0, 5'd7};
    #1;
    check("dual_same_addr", bus.rdata[31:0], 32'h22222222);

    // Different addresses: both land
    bus.wen0 = 1'b1; bus.waddr0 = 5'd10; bus.wdata0 = 32'hA5A5_0010;
    bus.wen1 = 1'b1; bus.waddr1 = 5'd11; bus.wdata1 = 32'h5A5A_0011;
    step();
    idle();
    bus.raddr = {5'd11, 5'd10};
    #1;
    check("dual_diff_p0", bus.rdata[31:0], 32'hA5A5_0010);
    check("dual_diff_p1", bus.rdata[63:32], 32'h5A5A_0011);

    // Zero register ignores writes and scoreboard sets
    bus.wen0 = 1'b1; bus.waddr0 = 5'd0; bus.wdata0 = 32'hFFFFFFFF;
    step();
    idle();
    bus.sb_set = 1'b1; bus.sb_addr = 5'd0;
    step();
    idle();
    bus.raddr = {5'd7, 5'd0};
    #1;
    check("zero_rdata", bus.rdata[31:0], 32'h0);
    check("zero_rbusy", {31'd0, bus.rbusy[0]}, 32'd0);
    check("p1_unaffected", bus.rdata[63:32], 32'h22222222);

    // Scoreboard on reg 9
    bus.sb_set = 1'b1; bus.sb_addr = 5'd9;
    step();
    idle();
    bus.raddr = {5'd9, 5'd9};
    #1;
    check("sb_set_busy", {31'd0, bus.rbusy[0]}, 32'd1);
    check("sb_set_busy_p1", {31'd0, bus.rbusy[1]}, 32'd1);
    bus.wen1 = 1'b1; bus.waddr1 = 5'd9; bus.wdata1 = 32'h0000_0909;
    bus.sb_set = 1'b1; bus.sb_addr = 5'd9;
    #1;
    check("sb_set_clr_same_cycle", {31'd0, bus.rbusy[0]}, 32'd1);
    step();
    idle();
    #1;
    check("sb_set_wins", {31'd0, bus.rbusy[0]}, 32'd1);
    check("sb_write_data", bus.rdata[31:0], 32'h0000_0909);
    bus.wen0 = 1'b1; bus.waddr0 = 5'd9; bus.wdata0 = 32'h0000_0999;
    #1;
`ifdef REG_FILE_MP_BYPASS_EN
    check("sb_clr_same_cycle", {31'd0, bus.rbusy[0]}, 32'd0);
`else
    check("sb_clr_same_cycle", {31'd0, bus.rbusy[0]}, 32'd1);
`endif
    step();
    idle();
    #1;
    check("sb_cleared", {31'd0, bus.rbusy[0]}, 32'd0);

    // Write-to-read visibility on reg 3
    bus.wen0 = 1'b1; bus.waddr0 = 5'd3; bus.wdata0 = 32'h0000_1234;
    step();
    idle();
    bus.raddr = {5'd0, 5'd3};
    bus.wen0 = 1'b1; bus.waddr0 = 5'd3; bus.wdata0 = 32'h0000_ABCD;
    #1;
`ifdef REG_FILE_MP_BYPASS_EN
    check("bypass_same_cycle", bus.rdata[31:0], 32'h0000_ABCD);
`else
    check("bypass_same_cycle", bus.rdata[31:0], 32'h0000_1234);
`endif
    step();
    idle();
    #1;
    check("bypass_next_cycle", bus.rdata[31:0], 32'h0000_ABCD);

    // Reset in the middle of the sweep restarts it
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("mid_sweep_init_done", {31'd0, bus.init_done}, 32'd0);
    rst = 1'b1;
    #2;
    check("mid_sweep_rst_init_done", {31'd0, bus.init_done}, 32'd0);
    step();
    rst = 1'b0;
    wait_init("restart_sweep_len");
    #1;
    check("restart_cleared_reg3", bus.rdata[31:0], 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end
endmodule
